// File: rtl/axi4_reg_bridge.sv
`timescale 1ns / 1ps
// AXI4 slave that splits INCR/FIXED bursts into single-beat register-bus accesses.
// One transaction in flight; reads and writes alternate priority when both are pending.
module axi4_reg_bridge #(
  parameter int unsigned       ADDR_W    = 31,
  parameter int unsigned       ID_W      = 4,
  parameter int unsigned       DATA_W    = 64,
  parameter logic [ADDR_W-1:0] ADDR_MASK = ADDR_W'(32'h0000_FFFF)
) (
  input  logic                clock,
  input  logic                reset,
  output logic                axi4_aw_ready,
  input  logic                axi4_aw_valid,
  input  logic [ID_W-1:0]     axi4_aw_id,
  input  logic [ADDR_W-1:0]   axi4_aw_addr,
  input  logic [7:0]          axi4_aw_len,
  input  logic [2:0]          axi4_aw_size,
  input  logic [1:0]          axi4_aw_burst,
  output logic                axi4_w_ready,
  input  logic                axi4_w_valid,
  input  logic [DATA_W-1:0]   axi4_w_data,
  input  logic [DATA_W/8-1:0] axi4_w_strb,
  input  logic                axi4_w_last,
  input  logic                axi4_b_ready,
  output logic                axi4_b_valid,
  output logic [ID_W-1:0]     axi4_b_id,
  output logic [1:0]          axi4_b_resp,
  output logic                axi4_ar_ready,
  input  logic                axi4_ar_valid,
  input  logic [ID_W-1:0]     axi4_ar_id,
  input  logic [ADDR_W-1:0]   axi4_ar_addr,
  input  logic [7:0]          axi4_ar_len,
  input  logic [2:0]          axi4_ar_size,
  input  logic [1:0]          axi4_ar_burst,
  input  logic                axi4_r_ready,
  output logic                axi4_r_valid,
  output logic [ID_W-1:0]     axi4_r_id,
  output logic [DATA_W-1:0]   axi4_r_data,
  output logic [1:0]          axi4_r_resp,
  output logic                axi4_r_last,
  output logic                reg_req_valid,
  input  logic                reg_req_ready,
  output logic                reg_we,
  output logic [ADDR_W-1:0]   reg_addr,
  output logic [DATA_W-1:0]   reg_wdata,
  output logic [DATA_W/8-1:0] reg_wstrb,
  input  logic                reg_rsp_valid,
  input  logic [DATA_W-1:0]   reg_rdata,
  input  logic                reg_err
);

  typedef enum logic [2:0] {
    StIdle, StRdReq, StRdWait, StRdResp, StWrData, StWrReq, StWrWait, StWrResp
  } state_e;

  state_e                state_q, state_d;
  logic                  prio_q, prio_d;  // 0: write wins a tie, 1: read wins
  logic [ID_W-1:0]       id_q, id_d;
  logic [ADDR_W-1:0]     addr_q, addr_d;
  logic [7:0]            cnt_q, cnt_d;
  logic [2:0]            size_q, size_d;
  logic [1:0]            burst_q, burst_d;
  logic                  bad_q, bad_d;
  logic                  err_q, err_d;
  logic                  pend_q, pend_d;  // response already seen during request acceptance
  logic [DATA_W-1:0]     data_q, data_d;
  logic [DATA_W/8-1:0]   strb_q, strb_d;

  logic              grant_wr, grant_rd, aw_bad, ar_bad;
  logic [ADDR_W-1:0] addr_nxt;

  assign grant_wr = axi4_aw_valid & (~axi4_ar_valid | ~prio_q);
  assign grant_rd = axi4_ar_valid & (~axi4_aw_valid | prio_q);
  assign aw_bad   = (axi4_aw_size > 3'd3) || (axi4_aw_burst == 2'b11);
  assign ar_bad   = (axi4_ar_size > 3'd3) || (axi4_ar_burst == 2'b11);
  assign addr_nxt = (burst_q == 2'b00) ? addr_q : addr_q + (ADDR_W'(1) << size_q);

  assign axi4_b_id   = id_q;
  assign axi4_r_id   = id_q;
  assign axi4_r_data = data_q;
  assign axi4_b_resp = (state_q == StWrResp && err_q) ? 2'b10 : 2'b00;
  assign axi4_r_resp = (state_q == StRdResp && err_q) ? 2'b10 : 2'b00;
  assign axi4_r_last = (state_q == StRdResp) && (cnt_q == 8'd0);
  assign reg_addr    = addr_q & ADDR_MASK;
  assign reg_wdata   = data_q;
  assign reg_wstrb   = strb_q;

  always_comb begin
    state_d = state_q;  prio_d  = prio_q;  id_d   = id_q;   addr_d = addr_q;
    cnt_d   = cnt_q;    size_d  = size_q;  burst_d = burst_q;
    bad_d   = bad_q;    err_d   = err_q;   pend_d = pend_q;
    data_d  = data_q;   strb_d  = strb_q;
    axi4_aw_ready = 1'b0;  axi4_ar_ready = 1'b0;  axi4_w_ready  = 1'b0;
    axi4_b_valid  = 1'b0;  axi4_r_valid  = 1'b0;
    reg_req_valid = 1'b0;  reg_we        = 1'b0;

    unique case (state_q)
      StIdle: begin
        axi4_aw_ready = grant_wr;
        axi4_ar_ready = grant_rd;
        if (grant_wr) begin
          id_d   = axi4_aw_id;    addr_d  = axi4_aw_addr;  cnt_d = axi4_aw_len;
          size_d = axi4_aw_size;  burst_d = axi4_aw_burst;
          bad_d  = aw_bad;        err_d   = aw_bad;        pend_d = 1'b0;
          prio_d = ~prio_q;       state_d = StWrData;
        end else if (grant_rd) begin
          id_d   = axi4_ar_id;    addr_d  = axi4_ar_addr;  cnt_d = axi4_ar_len;
          size_d = axi4_ar_size;  burst_d = axi4_ar_burst;
          bad_d  = ar_bad;        err_d   = ar_bad;        pend_d = 1'b0;
          data_d = '0;            prio_d  = ~prio_q;       state_d = StRdReq;
        end
      end
      StRdReq: begin
        if (bad_q) begin
          state_d = StRdResp;
        end else begin
          reg_req_valid = 1'b1;
          if (reg_req_ready) begin
            state_d = StRdWait;
            if (reg_rsp_valid) begin
              data_d = reg_rdata;  err_d = reg_err;  pend_d = 1'b1;
            end
          end
        end
      end
      StRdWait: begin
        if (pend_q) begin
          pend_d = 1'b0;  state_d = StRdResp;
        end else if (reg_rsp_valid) begin
          data_d = reg_rdata;  err_d = reg_err;  state_d = StRdResp;
        end
      end
      StRdResp: begin
        axi4_r_valid = 1'b1;
        if (axi4_r_ready) begin
          if (cnt_q == 8'd0) begin
            state_d = StIdle;
          end else begin
            cnt_d = cnt_q - 8'd1;  addr_d = addr_nxt;  state_d = StRdReq;
          end
        end
      end
      StWrData: begin
        axi4_w_ready = 1'b1;
        if (axi4_w_valid) begin
          data_d = axi4_w_data;
          strb_d = axi4_w_strb;
          if (axi4_w_last && cnt_q != 8'd0) err_d = 1'b1;
          if (!bad_q) begin
            state_d = StWrReq;
          end else if (cnt_q == 8'd0) begin
            state_d = StWrResp;
          end else begin
            cnt_d = cnt_q - 8'd1;  addr_d = addr_nxt;
          end
        end
      end
      StWrReq: begin
        reg_req_valid = 1'b1;
        reg_we        = 1'b1;
        if (reg_req_ready) begin
          state_d = StWrWait;
          if (reg_rsp_valid) begin
            err_d = err_q | reg_err;  pend_d = 1'b1;
          end
        end
      end
      StWrWait: begin
        if (pend_q || reg_rsp_valid) begin
          pend_d = 1'b0;
          if (!pend_q) err_d = err_q | reg_err;
          if (cnt_q == 8'd0) begin
            state_d = StWrResp;
          end else begin
            cnt_d = cnt_q - 8'd1;  addr_d = addr_nxt;  state_d = StWrData;
          end
        end
      end
      StWrResp: begin
        axi4_b_valid = 1'b1;
        if (axi4_b_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    // Handshake outputs stay low for the whole reset pulse, even if valids are high.
    if (reset) begin
      axi4_aw_ready = 1'b0;  axi4_ar_ready = 1'b0;  axi4_w_ready  = 1'b0;
      axi4_b_valid  = 1'b0;  axi4_r_valid  = 1'b0;
      reg_req_valid = 1'b0;  reg_we        = 1'b0;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;  prio_q  <= 1'b0;  id_q  <= '0;   addr_q <= '0;
      cnt_q   <= '0;      size_q  <= '0;    burst_q <= '0;
      bad_q   <= 1'b0;    err_q   <= 1'b0;  pend_q <= 1'b0;
      data_q  <= '0;      strb_q  <= '0;
    end else begin
      state_q <= state_d;  prio_q  <= prio_d;  id_q  <= id_d;    addr_q <= addr_d;
      cnt_q   <= cnt_d;    size_q  <= size_d;  burst_q <= burst_d;
      bad_q   <= bad_d;    err_q   <= err_d;   pend_q <= pend_d;
      data_q  <= data_d;   strb_q  <= strb_d;
    end
  end

endmodule

// File: tb/tb_axi4_reg_bridge.sv
`timescale 1ns / 1ps
// Directed bench for axi4_reg_bridge: a register-bus responder logs every access
// and answers one cycle after acceptance; AXI traffic is driven from one initial block.
module tb_axi4_reg_bridge;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  logic        aw_ready, aw_valid, w_ready, w_valid, w_last, b_ready, b_valid;
  logic [3:0]  aw_id, b_id, ar_id, r_id;
  logic [30:0] aw_addr, ar_addr;
  logic [7:0]  aw_len, ar_len, w_strb;
  logic [2:0]  aw_size, ar_size;
  logic [1:0]  aw_burst, ar_burst, b_resp, r_resp;
  logic [63:0] w_data, r_data;
  logic        ar_ready, ar_valid, r_ready, r_valid, r_last;
  logic        reg_req_valid, reg_req_ready, reg_we, reg_rsp_valid, reg_err;
  logic [30:0] reg_addr;
  logic [63:0] reg_wdata, reg_rdata;
  logic [7:0]  reg_wstrb;

  axi4_reg_bridge dut (
    .clock(clock), .reset(reset),
    .axi4_aw_ready(aw_ready), .axi4_aw_valid(aw_valid), .axi4_aw_id(aw_id),
    .axi4_aw_addr(aw_addr), .axi4_aw_len(aw_len), .axi4_aw_size(aw_size),
    .axi4_aw_burst(aw_burst),
    .axi4_w_ready(w_ready), .axi4_w_valid(w_valid), .axi4_w_data(w_data),
    .axi4_w_strb(w_strb), .axi4_w_last(w_last),
    .axi4_b_ready(b_ready), .axi4_b_valid(b_valid), .axi4_b_id(b_id), .axi4_b_resp(b_resp),
    .axi4_ar_ready(ar_ready), .axi4_ar_valid(ar_valid), .axi4_ar_id(ar_id),
    .axi4_ar_addr(ar_addr), .axi4_ar_len(ar_len), .axi4_ar_size(ar_size),
    .axi4_ar_burst(ar_burst),
    .axi4_r_ready(r_ready), .axi4_r_valid(r_valid), .axi4_r_id(r_id), .axi4_r_data(r_data),
    .axi4_r_resp(r_resp), .axi4_r_last(r_last),
    .reg_req_valid(reg_req_valid), .reg_req_ready(reg_req_ready), .reg_we(reg_we),
    .reg_addr(reg_addr), .reg_wdata(reg_wdata), .reg_wstrb(reg_wstrb),
    .reg_rsp_valid(reg_rsp_valid), .reg_rdata(reg_rdata), .reg_err(reg_err)
  );

  wire [186:0] all_out = {aw_ready, w_ready, b_valid, b_id, b_resp, ar_ready, r_valid, r_id,
                          r_data, r_resp, r_last, reg_req_valid, reg_we, reg_addr, reg_wdata,
                          reg_wstrb};

  int checks = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Register-bus responder and access log
  logic        rsp_en = 1'b1;
  logic [63:0] rd_base = '0;
  int          base = 0;
  int          err_seq = -1;
  logic        pend_rsp;
  int          pend_seq = -1;
  logic [30:0] log_addr[$];
  logic        log_we[$];
  logic [63:0] log_wdata[$];
  logic [7:0]  log_strb[$];

  always @(posedge clock or posedge reset) begin
    if (reset) begin
      pend_rsp <= 1'b0;
    end else if (reg_req_valid && reg_req_ready) begin
      pend_seq <= log_addr.size();
      pend_rsp <= 1'b1;
      log_addr.push_back(reg_addr);
      log_we.push_back(reg_we);
      log_wdata.push_back(reg_wdata);
      log_strb.push_back(reg_wstrb);
    end else if (reg_rsp_valid) begin
      pend_rsp <= 1'b0;
    end
  end

  always @(negedge clock) begin
    reg_rsp_valid = pend_rsp && rsp_en && !reset;
    reg_rdata     = rd_base + 64'(pend_seq - base);
    reg_err       = (pend_seq == err_seq);
  end

  // AXI master helpers; all driving happens at the falling edge
  logic [63:0] wd[8];
  logic [7:0]  ws[8];
  logic [63:0] rb_data[8];
  logic [1:0]  rb_resp[8];
  logic        rb_last[8];
  logic [3:0]  rb_id[8];

  task automatic aw_send(input logic [3:0] id, input logic [30:0] a, input logic [7:0] len,
                         input logic [2:0] sz, input logic [1:0] bu);
    int n = 0;
    aw_id = id; aw_addr = a; aw_len = len; aw_size = sz; aw_burst = bu; aw_valid = 1'b1;
    #1;
    while (!aw_ready && n < 50) begin @(negedge clock); #1; n++; end
    check("aw_handshake", aw_ready, 1);
    @(negedge clock);
    aw_valid = 1'b0;
  endtask

  task automatic ar_send(input logic [3:0] id, input logic [30:0] a, input logic [7:0] len,
                         input logic [2:0] sz, input logic [1:0] bu);
    int n = 0;
    ar_id = id; ar_addr = a; ar_len = len; ar_size = sz; ar_burst = bu; ar_valid = 1'b1;
    #1;
    while (!ar_ready && n < 50) begin @(negedge clock); #1; n++; end
    check("ar_handshake", ar_ready, 1);
    @(negedge clock);
    ar_valid = 1'b0;
  endtask

  task automatic w_send(input int nb);
    for (int i = 0; i < nb; i++) begin
      int n = 0;
      w_data = wd[i]; w_strb = ws[i]; w_last = (i == nb - 1); w_valid = 1'b1;
      #1;
      while (!w_ready && n < 50) begin @(negedge clock); #1; n++; end
      check("w_handshake", w_ready, 1);
      @(negedge clock);
    end
    w_valid = 1'b0; w_last = 1'b0;
  endtask

  task automatic b_collect();
    int n = 0;
    b_ready = 1'b1;
    #1;
    while (!b_valid && n < 50) begin @(negedge clock); #1; n++; end
    check("b_valid", b_valid, 1);
    rb_resp[0] = b_resp; rb_id[0] = b_id;
    @(negedge clock);
    b_ready = 1'b0;
  endtask

  task automatic r_collect(input int nb);
    r_ready = 1'b1;
    for (int i = 0; i < nb; i++) begin
      int n = 0;
      #1;
      while (!r_valid && n < 50) begin @(negedge clock); #1; n++; end
      check("r_valid", r_valid, 1);
      rb_data[i] = r_data; rb_resp[i] = r_resp; rb_last[i] = r_last; rb_id[i] = r_id;
      @(negedge clock);
    end
    r_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    aw_valid = 0; aw_id = 0; aw_addr = 0; aw_len = 0; aw_size = 0; aw_burst = 0;
    w_valid = 1; w_data = '1; w_strb = '1; w_last = 0; b_ready = 1;
    ar_valid = 0; ar_id = 0; ar_addr = 0; ar_len = 0; ar_size = 0; ar_burst = 0;
    r_ready = 1; reg_req_ready = 1;

    // Reset: outputs stay zero even with both address channels requesting
    aw_valid = 1; ar_valid = 1;
    repeat (3) @(negedge clock);
    #1 check("reset_outputs_zero", all_out, '0);
    aw_valid = 0; ar_valid = 0; w_valid = 0; b_ready = 0; r_ready = 0;
    @(negedge clock); reset = 0;
    #1 check("post_reset_idle", all_out, '0);
    @(negedge clock);

    // Single read
    base = log_addr.size(); rd_base = 64'hDEADBEEF_CAFEF00D;
    ar_send(4'h5, 31'h6003_0008, 8'd0, 3'd3, 2'b01);
    r_collect(1);
    check("rd1_data", rb_data[0], 64'hDEADBEEF_CAFEF00D);
    check("rd1_resp", rb_resp[0], 2'b00);
    check("rd1_last", rb_last[0], 1'b1);
    check("rd1_id", rb_id[0], 4'h5);
    check("rd1_nacc", log_addr.size() - base, 1);
    check("rd1_addr_we", {log_addr[base], log_we[base]}, {31'h0008, 1'b0});

    // INCR write, four beats, zero strobe on last beat
    base = log_addr.size();
    wd[0] = 64'h1111_0000_0000_0000; wd[1] = 64'h2222_0000_0000_0001;
    wd[2] = 64'h3333_0000_0000_0002; wd[3] = 64'h4444_0000_0000_0003;
    ws[0] = 8'hFF; ws[1] = 8'h0F; ws[2] = 8'hF0; ws[3] = 8'h00;
    aw_send(4'h3, 31'h6003_0000, 8'd3, 3'd3, 2'b01);
    w_send(4);
    b_collect();
    check("wr_incr_bresp", rb_resp[0], 2'b00);
    check("wr_incr_bid", rb_id[0], 4'h3);
    check("wr_incr_nacc", log_addr.size() - base, 4);
    for (int i = 0; i < 4; i++)
      check("wr_incr_beat", {log_addr[base+i], log_we[base+i], log_wdata[base+i],
                             log_strb[base+i]},
            {31'(8 * i), 1'b1, wd[i], ws[i]});

    // FIXED read, three beats at the same address
    base = log_addr.size(); rd_base = 64'h0000_0000_0000_1000;
    ar_send(4'h9, 31'h6003_0010, 8'd2, 3'd3, 2'b00);
    r_collect(3);
    check("rd_fixed_nacc", log_addr.size() - base, 3);
    for (int i = 0; i < 3; i++) begin
      check("rd_fixed_addr", log_addr[base+i], 31'h0010);
      check("rd_fixed_data", rb_data[i], 64'h1000 + 64'(i));
      check("rd_fixed_last", rb_last[i], (i == 2));
    end

    // Write burst with slave error on beat 2 of 4
    base = log_addr.size(); err_seq = base + 1;
    aw_send(4'h2, 31'h6003_0100, 8'd3, 3'd3, 2'b01);
    w_send(4);
    b_collect();
    err_seq = -1;
    check("wr_err_nacc", log_addr.size() - base, 4);
    check("wr_err_bresp", rb_resp[0], 2'b10);

    // Read with size 4 is rejected without a register access
    base = log_addr.size();
    ar_send(4'hA, 31'h6003_0000, 8'd0, 3'd4, 2'b01);
    r_collect(1);
    check("rd_bad_nacc", log_addr.size() - base, 0);
    check("rd_bad_resp", rb_resp[0], 2'b10);
    check("rd_bad_last", rb_last[0], 1'b1);

    // Request held while the peripheral stalls for five cycles
    base = log_addr.size();
    aw_send(4'h6, 31'h6003_0120, 8'd0, 3'd3, 2'b01);
    reg_req_ready = 0;
    wd[0] = 64'hA5A5_5A5A_0123_4567; ws[0] = 8'h3C;
    w_send(1);
    for (int i = 0; i < 5; i++) begin
      #1 check("stall_stable", {reg_req_valid, reg_we, reg_addr, reg_wdata, reg_wstrb},
                               {1'b1, 1'b1, 31'h0120, 64'hA5A5_5A5A_0123_4567, 8'h3C});
      @(negedge clock);
    end
    reg_req_ready = 1;
    b_collect();
    check("stall_bresp", rb_resp[0], 2'b00);
    check("stall_nacc", log_addr.size() - base, 1);

    // Simultaneous AW/AR twice after a fresh reset: write first, read second each time
    reset = 1; @(negedge clock); reset = 0; @(negedge clock);
    for (int k = 0; k < 2; k++) begin
      base = log_addr.size(); rd_base = 64'h0BAD_F00D_0000_0000;
      aw_id = 4'(2 * k + 1); aw_addr = 31'h6003_0200; aw_len = 0; aw_size = 3; aw_burst = 1;
      ar_id = 4'(2 * k + 2); ar_addr = 31'h6003_0208; ar_len = 0; ar_size = 3; ar_burst = 1;
      aw_valid = 1; ar_valid = 1;
      #1 check("arb_grant", {aw_ready, ar_ready}, 2'b10);
      @(negedge clock); aw_valid = 0;
      wd[0] = 64'h77; ws[0] = 8'hFF;
      w_send(1);
      #1 check("arb_ar_blocked", ar_ready, 1'b0);
      b_collect();
      check("arb_bid", rb_id[0], 4'(2 * k + 1));
      begin
        int n = 0;
        #1;
        while (!ar_ready && n < 50) begin @(negedge clock); #1; n++; end
        check("arb_ar_handshake", ar_ready, 1);
      end
      @(negedge clock); ar_valid = 0;
      r_collect(1);
      check("arb_rid", rb_id[0], 4'(2 * k + 2));
      check("arb_order", {log_we[base], log_addr[base], log_we[base+1], log_addr[base+1]},
                         {1'b1, 31'h0200, 1'b0, 31'h0208});
    end

    // Reset while a read waits for its response
    rsp_en = 0;
    ar_send(4'hC, 31'h6003_0030, 8'd0, 3'd3, 2'b01);
    @(negedge clock);
    #2 reset = 1;
    #1 check("async_reset_zero", all_out, '0);
    @(negedge clock); reset = 0; rsp_en = 1;
    repeat (2) begin
      #1 check("no_stale_r", {r_valid, reg_req_valid}, 2'b00);
      @(negedge clock);
    end
    base = log_addr.size();
    wd[0] = 64'h0000_0000_0000_1234; ws[0] = 8'hFF;
    aw_send(4'h7, 31'h6003_0040, 8'd0, 3'd3, 2'b01);
    w_send(1);
    b_collect();
    check("post_rst_bresp", rb_resp[0], 2'b00);
    check("post_rst_bid", rb_id[0], 4'h7);
    check("post_rst_acc", {log_addr[base], log_we[base], log_wdata[base]},
                          {31'h0040, 1'b1, 64'h1234});

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
